array_scan_reader: RTL and testbench
====================================

ARRAY_SCAN_READER -- requirements
Module: array_scan_reader

Interface
REQ-001 SHALL have parameter ROWS, 16, number of cell-array rows (2..64).
REQ-002 SHALL have parameter COLS, 16, number of cell-array columns (2..64).
REQ-003 SHALL have port FPGA_CLK_50  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ARRAY_IN  input  ROWS*COLS  live cell array; bit r*COLS+c = cell [r][c].
REQ-006 SHALL have port START  input  1  request a frame readout; sampled only in IDLE.
REQ-007 SHALL have port ABORT  input  1  synchronous cancel of the frame in progress.
REQ-008 SHALL have port SER_READY  input  1  downstream accepts SER_DATA this cycle.
REQ-009 SHALL have port SER_DATA  output  1  current serialized cell bit.
REQ-010 SHALL have port SER_VALID  output  1  SER_DATA is valid.
REQ-011 SHALL have port SER_LAST  output  1  the current bit is the final bit of the frame.
REQ-012 SHALL have port BUSY  output  1  high in SHIFT and DONE states.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse after a completed frame.
REQ-014 SHALL have port FRAME_CNT  output  8  count of completed frames, modulo 256.

Function
REQ-015 SHALL implement states IDLE, SHIFT and DONE, with registered outputs only.
REQ-016 In IDLE with START=1 and ABORT=0, SHALL capture ARRAY_IN into a snapshot register, clear the bit index to 0, and enter SHIFT on the same edge.
REQ-017 SHALL assert SER_VALID the cycle after the START edge, giving a first-bit latency of 1 cycle.
REQ-018 SHALL drive SER_DATA = snapshot[index], with index 0 first: row 0, col 0 .. col COLS-1, then row 1, and so on.
REQ-019 SHALL use an index counter of width clog2(ROWS*COLS) that advances only on a transfer (SER_VALID & SER_READY).
REQ-020 SHALL hold SER_DATA, SER_LAST and SER_VALID stable while SER_VALID=1 and SER_READY=0; there is no timeout.
REQ-021 SHALL assert SER_LAST only while index = ROWS*COLS-1 in SHIFT.
REQ-022 On a transfer with SER_LAST=1, SHALL enter DONE, deassert SER_VALID, and increment FRAME_CNT; FRAME_CNT wraps from 255 to 0.
REQ-023 SHALL assert DONE for exactly one cycle while in DONE, then return to IDLE.
REQ-024 SHALL ignore START outside IDLE: no recapture and no restart.
REQ-025 SHALL leave the snapshot unaffected by changes on ARRAY_IN after capture.
REQ-026 ABORT=1 in SHIFT or DONE SHALL force IDLE on the next edge, deassert SER_VALID, SER_LAST and DONE, and leave FRAME_CNT unchanged.
REQ-027 ABORT coincident with the final transfer SHALL win: no DONE pulse and no FRAME_CNT increment.
REQ-028 START and ABORT together in IDLE SHALL leave the block in IDLE with no capture.
REQ-029 SHALL start a new frame from START in IDLE the cycle after DONE, with no extra gap.

Reset
REQ-030 RESET_N=0 SHALL asynchronously force IDLE, index=0, SER_DATA=0, SER_VALID=0, SER_LAST=0, BUSY=0, DONE=0, FRAME_CNT=0, and snapshot=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately; the partial frame is not counted.
REQ-032 After RESET_N rises, the first START SHALL be honoured on the first clock edge after deassertion.

Verification
REQ-033 Default parameters, ARRAY_IN with only bit 0 set and bit 255 set, START pulse, SER_READY=1 -> SER_VALID at cycle +1, 256 beats, SER_DATA=1 on beats 0 and 255 only, SER_LAST on beat 255, DONE one cycle later, FRAME_CNT=1.
REQ-034 SER_READY toggled 0,1,0,1 with random stalls -> SER_DATA stable during each stall, still exactly 256 transfers, bit order matches the snapshot.
REQ-035 ARRAY_IN inverted after the START edge -> serialized stream equals the pre-inversion value; START re-pulsed mid-frame is ignored.
REQ-036 ABORT after beat 100 -> IDLE next edge, SER_VALID=0, no DONE, FRAME_CNT unchanged; a following START restarts at bit 0.
REQ-037 RESET_N pulsed low asynchronously mid-frame (between clock edges) -> all outputs 0 immediately; ABORT coincident with beat 255 -> no DONE.
REQ-038 256 back-to-back frames -> FRAME_CNT wraps to 0 and DONE pulses 256 times.

Source files
------------

// File: rtl/array_scan_reader.sv
// rtl/array_scan_reader.sv - snapshot a live cell array and serialize it one bit per handshake
//
// Ports:
//   FPGA_CLK_50  in   sole clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   ARRAY_IN     in   live cell array, bit r*COLS+c = cell [r][c]
//   START        in   request a frame readout (honoured only in IDLE)
//   ABORT        in   synchronous cancel of the frame in progress
//   SER_READY    in   downstream accepts SER_DATA this cycle
//   SER_DATA     out  current serialized cell bit
//   SER_VALID    out  SER_DATA is valid
//   SER_LAST     out  current bit is the final bit of the frame
//   BUSY         out  frame in progress (SHIFT or DONE)
//   DONE         out  one-cycle pulse after a completed frame
//   FRAME_CNT    out  completed frames, modulo 256
module array_scan_reader #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                 FPGA_CLK_50,
  input  logic                 RESET_N,
  input  logic [ROWS*COLS-1:0] ARRAY_IN,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 SER_READY,
  output logic                 SER_DATA,
  output logic                 SER_VALID,
  output logic                 SER_LAST,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [7:0]           FRAME_CNT
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    snap_q, snap_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   nxt_idx;
  logic            data_d, valid_d, last_d, busy_d, done_d;
  logic [7:0]      cnt_d;

  assign nxt_idx = idx_q + IW'(1);

  // Every output is a register; the combinational block computes the value
  // each one takes on the next edge, so the outputs of the following cycle
  // are already resolved (data of the next bit, LAST one beat ahead).
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    data_d  = SER_DATA;
    valid_d = SER_VALID;
    last_d  = SER_LAST;
    done_d  = 1'b0;
    cnt_d   = FRAME_CNT;

    unique case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          snap_d  = ARRAY_IN;
          idx_d   = '0;
          data_d  = ARRAY_IN[0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (ABORT) begin
          state_d = S_IDLE;
          idx_d   = '0;
          data_d  = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (SER_VALID && SER_READY) begin
          if (SER_LAST) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = FRAME_CNT + 8'd1;
          end else begin
            idx_d  = nxt_idx;
            data_d = snap_q[nxt_idx];
            last_d = (nxt_idx == LAST_IDX);
          end
        end
      end

      S_DONE: begin
        // DONE is high for exactly this one cycle; ABORT here lands in the
        // same place, so it needs no separate branch.
        state_d = S_IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge FPGA_CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      SER_DATA  <= 1'b0;
      SER_VALID <= 1'b0;
      SER_LAST  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FRAME_CNT <= 8'd0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      SER_DATA  <= data_d;
      SER_VALID <= valid_d;
      SER_LAST  <= last_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      FRAME_CNT <= cnt_d;
    end
  end

endmodule

// File: tb/tb_array_scan_reader.sv
// tb/tb_array_scan_reader.sv - randomized self-checking bench for array_scan_reader
module tb_array_scan_reader;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int N    = ROWS * COLS;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] array_in;
  logic         start;
  logic         abort_i;
  logic         ser_ready;
  logic         ser_data;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;
  logic         done;
  logic [7:0]   frame_cnt;

  array_scan_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .FPGA_CLK_50 (clk),
    .RESET_N     (rst_n),
    .ARRAY_IN    (array_in),
    .START       (start),
    .ABORT       (abort_i),
    .SER_READY   (ser_ready),
    .SER_DATA    (ser_data),
    .SER_VALID   (ser_valid),
    .SER_LAST    (ser_last),
    .BUSY        (busy),
    .DONE        (done),
    .FRAME_CNT   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame-level reference: a frame is either not running, running at some
  // beat of a captured picture, or in its one-cycle completion phase.
  logic         m_active = 1'b0;
  logic         m_done   = 1'b0;
  int           m_beat   = 0;
  logic [N-1:0] m_bits   = '0;
  int           m_cnt    = 0;

  // Receiver-side record of the stream.
  logic [N-1:0] rx_buf = '0;
  int           rx_total = 0;
  int           rx_base  = 0;
  int           done_pulses = 0;
  int           ri;

  time t_rst  = 0;
  time t_last = 0;
  logic pv = 1'b0, pr = 1'b0, pa = 1'b0, pd = 1'b0, pl = 1'b0;
  logic rst_evt;

  always @(negedge rst_n) t_rst = $time;

  always @(posedge clk) begin
    rst_evt = (t_rst > t_last) || !rst_n;
    if (!rst_evt) begin
      // An offered bit that was not taken must be offered again unchanged.
      if (pv && !pr && !pa) begin
        chk("stall_valid", 32'(ser_valid), 32'd1);
        chk("stall_data",  32'(ser_data),  32'(pd));
        chk("stall_last",  32'(ser_last),  32'(pl));
      end
      if (ser_valid && ser_ready && !abort_i) begin
        ri = rx_total - rx_base;
        if (ri >= 0 && ri < N) rx_buf[ri] = ser_data;
        rx_total++;
      end
      if (done) done_pulses++;
    end
    pv = ser_valid; pr = ser_ready; pa = abort_i; pd = ser_data; pl = ser_last;

    if (rst_evt) begin
      m_active = 1'b0; m_done = 1'b0; m_beat = 0; m_bits = '0; m_cnt = 0;
    end
    if (rst_n) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_active) begin
        if (abort_i) m_active = 1'b0;
        else if (ser_ready) begin
          if (m_beat == N - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_cnt    = (m_cnt + 1) % 256;
          end else begin
            m_beat++;
          end
        end
      end else if (start && !abort_i) begin
        m_active = 1'b1;
        m_beat   = 0;
        m_bits   = array_in;
      end
    end
    t_last = $time;

    #1;
    chk("valid",     32'(ser_valid), 32'(m_active));
    chk("last",      32'(ser_last),  32'(m_active && (m_beat == N - 1)));
    chk("busy",      32'(busy),      32'(m_active || m_done));
    chk("done",      32'(done),      32'(m_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    if (m_active) chk("data", 32'(ser_data), 32'(m_bits[m_beat]));
  end

  function automatic logic [N-1:0] rand_array();
    logic [N-1:0] a;
    for (int i = 0; i < N / 32; i++) a[i*32 +: 32] = $urandom;
    return a;
  endfunction

  // mode 0: always ready; 1: random stalls; 2: random stalls, ARRAY_IN
  // inverted after capture and START re-pulsed mid-frame.
  task automatic run_frame(input logic [N-1:0] arr, input int mode);
    int d0;
    int k;
    @(negedge clk);
    array_in  = arr;
    start     = 1'b1;
    ser_ready = 1'b1;
    rx_base   = rx_total;
    d0        = done_pulses;
    @(negedge clk);
    start = 1'b0;
    chk("first_bit_latency", 32'(ser_valid), 32'd1);
    if (mode == 2) array_in = ~arr;
    k = 0;
    while (done_pulses == d0 && k < 4000) begin
      ser_ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
      start     = (mode == 2 && k == 50) ? 1'b1 : 1'b0;
      @(negedge clk);
      k++;
    end
    start     = 1'b0;
    ser_ready = 1'b1;
    chk("frame_timeout", 32'(done_pulses - d0), 32'd1);
    chk("frame_beats",   32'(rx_total - rx_base), 32'(N));
    chk("frame_stream",  32'(rx_buf == arr), 32'd1);
  endtask

  logic [N-1:0] arr;
  int exp_frames;
  int d0;
  int k;

  initial begin
    rst_n = 1'b0; array_in = '0; start = 1'b0; abort_i = 1'b0; ser_ready = 1'b0;
    exp_frames = 0;
    #12;
    chk("reset_valid", 32'(ser_valid), 32'd0);
    chk("reset_data",  32'(ser_data),  32'd0);
    chk("reset_last",  32'(ser_last),  32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_done",  32'(done),      32'd0);
    chk("reset_cnt",   32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Corner cells only: ones on beats 0 and N-1.
    arr = '0; arr[0] = 1'b1; arr[N-1] = 1'b1;
    run_frame(arr, 0);
    exp_frames++;
    chk("corner_cnt",   32'(frame_cnt), 32'd1);
    chk("corner_beat0", 32'(rx_buf[0]), 32'd1);
    chk("corner_beat255", 32'(rx_buf[N-1]), 32'd1);
    chk("corner_ones",  32'($countones(rx_buf)), 32'd2);

    // Random pictures with random backpressure.
    run_frame(rand_array(), 1); exp_frames++;
    run_frame(rand_array(), 1); exp_frames++;
    run_frame(rand_array(), 2); exp_frames++;
    chk("cnt_after_stalls", 32'(frame_cnt), 32'(exp_frames));

    // Abort after beat 100.
    arr = rand_array();
    @(negedge clk);
    array_in = arr; start = 1'b1; ser_ready = 1'b1;
    rx_base = rx_total; d0 = done_pulses;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ((rx_total - rx_base) < 101 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach", 32'(rx_total - rx_base), 32'd101);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_valid", 32'(ser_valid), 32'd0);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_cnt",   32'(frame_cnt), 32'(exp_frames));
    chk("abort_nodone", 32'(done_pulses - d0), 32'd0);
    run_frame(arr, 0); exp_frames++;

    // Asynchronous reset between clock edges mid-frame.
    @(negedge clk);
    array_in = rand_array(); start = 1'b1; ser_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(ser_valid), 32'd0);
    chk("async_data",  32'(ser_data),  32'd0);
    chk("async_last",  32'(ser_last),  32'd0);
    chk("async_busy",  32'(busy),      32'd0);
    chk("async_done",  32'(done),      32'd0);
    chk("async_cnt",   32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; array_in = rand_array(); rx_base = rx_total;
    @(negedge clk);
    start = 1'b0;
    chk("start_after_reset", 32'(ser_valid), 32'd1);

    // ABORT on the final beat wins over completion.
    k = 0;
    while (!ser_last && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_last", 32'(ser_last), 32'd1);
    abort_i = 1'b1; d0 = done_pulses;
    @(negedge clk);
    abort_i = 1'b0;
    @(negedge clk);
    chk("last_abort_nodone", 32'(done_pulses - d0), 32'd0);
    chk("last_abort_cnt",    32'(frame_cnt), 32'd0);
    chk("last_abort_valid",  32'(ser_valid), 32'd0);

    // 256 back-to-back frames: counter wraps back to zero.
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    d0 = done_pulses; start = 1'b1; ser_ready = 1'b1; array_in = rand_array();
    k = 0;
    while ((done_pulses - d0) < 256 && k < 70000) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("b2b_done_pulses", 32'(done_pulses - d0), 32'd256);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_wrap_cnt", 32'(frame_cnt), 32'd0);
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
